// File: rtl/zero_mask_decompressor.sv
// Rebuilds 256-bit packet beats from a zero-suppressed mask/literal token stream.
// Optional DECOMP_ZERO_RUN_EN: a mask==0 record expands to run+1 zero beats.

module zero_mask_decompressor_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 8,
  parameter int LANE       = 0
) (
  input  logic [NUM_DATA-1:0]                 mask,
  input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] lits,
  output logic [DATA_WIDTH-1:0]               word
);
  localparam int IW = $clog2(NUM_DATA);
  localparam logic [NUM_DATA-1:0] BELOW = NUM_DATA'((1 << LANE) - 1);

  logic [NUM_DATA-1:0] lo;
  logic [IW-1:0]       idx;

  // Literal slot for this lane = number of set mask bits below it.
  always_comb begin
    lo  = mask & BELOW;
    idx = '0;
    for (int b = 0; b < NUM_DATA; b++) idx = idx + IW'(lo[b]);
    word = mask[LANE] ? lits[idx] : '0;
  end
endmodule

module zero_mask_decompressor #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 8,
  parameter int BUF_WORDS  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wrt_en,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] data_in,
  input  logic                           tvalid_in,
  input  logic                           tlast_in,
  input  logic                           tready_in,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
  output logic                           tready_out,
  output logic                           tvalid_out,
  output logic                           tlast_out,
  output logic                           err_out
);
  localparam int CW  = $clog2(BUF_WORDS + 1);
  localparam int AW  = $clog2(BUF_WORDS);
  localparam int DIW = $clog2(NUM_DATA);
  localparam logic [CW-1:0] BUF_N  = CW'(BUF_WORDS);
  localparam logic [CW-1:0] BEAT_N = CW'(NUM_DATA);

  typedef enum logic [1:0] {S_DEC = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

  logic [DATA_WIDTH-1:0] buf_q [BUF_WORDS];
  logic [DATA_WIDTH-1:0] buf_d [BUF_WORDS];
  logic [CW-1:0]         cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic                  tl_pend_q, tl_pend_d;
  logic                  rdy_q, rdy_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH*NUM_DATA-1:0] dout_q, dout_d;
`ifdef DECOMP_ZERO_RUN_EN
  logic [7:0]            run_q, run_d;
  logic                  run_last_q, run_last_d;
`endif

  logic [NUM_DATA-1:0]                 mask;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] lits, dec, din_w;
  logic [CW-1:0]                       need, consume, base;
  logic                                complete, out_free, accept, flush;

  assign mask       = buf_q[0][NUM_DATA-1:0];
  assign din_w      = data_in;
  assign tready_out = rdy_q && wrt_en;
  assign data_out   = dout_q;
  assign tvalid_out = tvalid_q;
  assign tlast_out  = tlast_q;
  assign err_out    = err_q;

  always_comb begin
    for (int i = 0; i < NUM_DATA; i++) lits[i] = buf_q[i+1];
    need = CW'(1);
    for (int b = 0; b < NUM_DATA; b++) need = need + CW'(mask[b]);
  end

  for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_lane
    zero_mask_decompressor_lane #(
      .DATA_WIDTH(DATA_WIDTH), .NUM_DATA(NUM_DATA), .LANE(gi)
    ) u_lane (
      .mask(mask), .lits(lits), .word(dec[gi])
    );
  end

  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    tl_pend_d = tl_pend_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    dout_d    = dout_q;
    err_d     = 1'b0;
`ifdef DECOMP_ZERO_RUN_EN
    run_d      = run_q;
    run_last_d = run_last_q;
`endif
    consume  = '0;
    flush    = 1'b0;
    complete = (cnt_q >= need);
    out_free = !tvalid_q || tready_in;
    accept   = tvalid_in && tready_out;

    if (wrt_en) begin
      if (tvalid_q && tready_in) tvalid_d = 1'b0;
      case (state_q)
        S_DEC: begin
          if (complete && out_free) begin
            consume  = need;
            dout_d   = dec;
            tvalid_d = 1'b1;
            tlast_d  = buf_q[0][31];
`ifdef DECOMP_ZERO_RUN_EN
            if (mask == '0 && buf_q[0][23:16] != 8'd0) begin
              tlast_d    = 1'b0;
              run_d      = buf_q[0][23:16];
              run_last_d = buf_q[0][31];
              state_d    = S_RUN;
            end
`endif
            if (buf_q[0][31]) begin
              flush = 1'b1;
              if (tl_pend_q) tl_pend_d = 1'b0;
              else begin
                // Packet ended before its tlast beat: close it and skip the rest.
                err_d   = 1'b1;
                tlast_d = 1'b1;
                state_d = (accept && tlast_in) ? S_DEC : S_DRAIN;
              end
            end
          end else if (tl_pend_q && !complete) begin
            flush     = 1'b1;
            tl_pend_d = 1'b0;
            err_d     = 1'b1;
          end
          if (accept && tlast_in && !flush) tl_pend_d = 1'b1;
        end
`ifdef DECOMP_ZERO_RUN_EN
        S_RUN: begin
          if (out_free) begin
            dout_d   = '0;
            tvalid_d = 1'b1;
            tlast_d  = (run_q == 8'd1) ? run_last_q : 1'b0;
            run_d    = run_q - 8'd1;
            if (run_q == 8'd1) state_d = S_DEC;
          end
        end
`endif
        S_DRAIN: if (accept && tlast_in) state_d = S_DEC;
        default: state_d = S_DEC;
      endcase
    end

    base = cnt_q - consume;
    if (flush) cnt_d = '0;
    else begin
      for (int j = 0; j < BUF_WORDS; j++)
        buf_d[j] = (CW'(j) + consume < BUF_N) ? buf_q[AW'(CW'(j) + consume)] : '0;
      cnt_d = base;
      if (accept && state_q == S_DEC) begin
        for (int j = 0; j < BUF_WORDS; j++)
          if (CW'(j) >= base && CW'(j) < base + BEAT_N)
            buf_d[j] = din_w[DIW'(CW'(j) - base)];
        cnt_d = base + BEAT_N;
      end
    end

    rdy_d = (state_d == S_DRAIN) || (cnt_d <= BEAT_N && !tl_pend_d && state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < BUF_WORDS; j++) buf_q[j] <= '0;
      cnt_q     <= '0;
      state_q   <= S_DEC;
      tl_pend_q <= 1'b0;
      rdy_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
`ifdef DECOMP_ZERO_RUN_EN
      run_q      <= '0;
      run_last_q <= 1'b0;
`endif
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      tl_pend_q <= tl_pend_d;
      rdy_q     <= rdy_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
`ifdef DECOMP_ZERO_RUN_EN
      run_q      <= run_d;
      run_last_q <= run_last_d;
`endif
    end
  end
endmodule
